// File: rtl/bird_sprite_drawer.sv
// bird_sprite_drawer: two-frame flapping bird sprite reader.
// Decides per pixel whether the scan position falls inside the bird's box.
// Fetches the colour from the active wing frame, with a fixed 2-cycle latency.
// Optional macro BIRD_MIRROR_EN adds a faceLeft input that mirrors the sprite
// horizontally.
module bird_sprite_drawer #(
  parameter int         OBJECT_WIDTH_X       = 32,
  parameter int         OBJECT_HEIGHT_Y      = 32,
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter int         FLAP_PERIOD          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
`ifdef BIRD_MIRROR_EN
  input  logic        faceLeft,
`endif
  input  logic [7:0]  wings_up_object_colors   [OBJECT_HEIGHT_Y][OBJECT_WIDTH_X],
  input  logic [7:0]  wings_down_object_colors [OBJECT_HEIGHT_Y][OBJECT_WIDTH_X],
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        wingsUp
);

  localparam int                XW        = $clog2(OBJECT_WIDTH_X);
  localparam int                YW        = $clog2(OBJECT_HEIGHT_Y);
  localparam logic signed [11:0] WIDTH12  = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] HEIGHT12 = 12'(OBJECT_HEIGHT_Y);
  localparam logic [7:0]        FLAP_LAST = 8'(FLAP_PERIOD - 1);

  typedef enum logic [1:0] {HIDDEN, FLAP_UP, FLAP_DOWN} state_e;

  state_e          state_q, state_d;
  logic [7:0]      flap_cnt_q, flap_cnt_d;

  logic            s1_inside_q, s1_inside_d;
  logic [XW-1:0]   s1_col_q, s1_col_d;
  logic [YW-1:0]   s1_row_q, s1_row_d;
  logic            s1_up_q, s1_up_d;
  logic            s1_face_left_q, s1_face_left_d;

  logic            draw_q, draw_d;
  logic [7:0]      rgb_q, rgb_d;

  logic signed [11:0] off_x, off_y;
  logic [XW-1:0]      col_idx;
  logic [7:0]         colour;

  // Offsets from the signed top-left corner; pixel coordinates are unsigned.
  assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  // Flap FSM next state: disable wins over everything, then count frame pulses.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    state_d    = state_q;
    flap_cnt_d = flap_cnt_q;
    if (!enable) begin
      state_d    = HIDDEN;
      flap_cnt_d = '0;
    end else begin
      unique case (state_q)
        HIDDEN: begin
          state_d    = FLAP_UP;
          flap_cnt_d = '0;
        end
        FLAP_UP, FLAP_DOWN: begin
          if (startOfFrame) begin
            if (flap_cnt_q == FLAP_LAST) begin
              flap_cnt_d = '0;
              state_d    = (state_q == FLAP_UP) ? FLAP_DOWN : FLAP_UP;
            end else begin
              flap_cnt_d = flap_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d    = HIDDEN;
          flap_cnt_d = '0;
        end
      endcase
    end
  end

  // Stage 1 inputs: inside test, low offset bits and the frame select captured together.
  always_comb begin
    s1_inside_d = enable && (state_q != HIDDEN) &&
                  !off_x[11] && (off_x < WIDTH12) &&
                  !off_y[11] && (off_y < HEIGHT12);
    s1_col_d    = off_x[XW-1:0];
    s1_row_d    = off_y[YW-1:0];
    s1_up_d     = (state_q != FLAP_DOWN);
`ifdef BIRD_MIRROR_EN
    s1_face_left_d = faceLeft;
`else
    s1_face_left_d = 1'b0;
`endif
  end

  // Stage 2 inputs: bitmap lookup and transparency decision.
  always_comb begin
    // Width is a power of two, so W-1-x is simply the bitwise complement.
    col_idx = s1_face_left_q ? ~s1_col_q : s1_col_q;
    colour  = s1_up_q ? wings_up_object_colors[s1_row_q][col_idx]
                      : wings_down_object_colors[s1_row_q][col_idx];
    draw_d  = s1_inside_q && (colour != TRANSPARENT_ENCODING);
    rgb_d   = draw_d ? colour : TRANSPARENT_ENCODING;
  end

  // State, counter and both pipeline stages, with synchronous reset flushing the pipe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q        <= HIDDEN;
      flap_cnt_q     <= '0;
      s1_inside_q    <= 1'b0;
      s1_col_q       <= '0;
      s1_row_q       <= '0;
      s1_up_q        <= 1'b1;
      s1_face_left_q <= 1'b0;
      draw_q         <= 1'b0;
      rgb_q          <= TRANSPARENT_ENCODING;
    end else begin
      state_q        <= state_d;
      flap_cnt_q     <= flap_cnt_d;
      s1_inside_q    <= s1_inside_d;
      s1_col_q       <= s1_col_d;
      s1_row_q       <= s1_row_d;
      s1_up_q        <= s1_up_d;
      s1_face_left_q <= s1_face_left_d;
      draw_q         <= draw_d;
      rgb_q          <= rgb_d;
    end
  end

  assign drawingRequest = draw_q;
  assign RGBout         = rgb_q;
  assign wingsUp        = (state_q != FLAP_DOWN);

endmodule

// File: tb/tb_bird_sprite_drawer.sv
// Directed testbench for bird_sprite_drawer; mirror checks only when BIRD_MIRROR_EN is defined.
module tb_bird_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        enable;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        faceLeft;
  logic [7:0]  up_mem   [32][32];
  logic [7:0]  down_mem [32][32];
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        wingsUp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bird_sprite_drawer dut (
    .clk                      (clk),
    .reset                    (reset),
    .startOfFrame             (startOfFrame),
    .enable                   (enable),
    .pixelX                   (pixelX),
    .pixelY                   (pixelY),
    .topLeftX                 (topLeftX),
    .topLeftY                 (topLeftY),
`ifdef BIRD_MIRROR_EN
    .faceLeft                 (faceLeft),
`endif
    .wings_up_object_colors   (up_mem),
    .wings_down_object_colors (down_mem),
    .drawingRequest           (drawingRequest),
    .RGBout                   (RGBout),
    .wingsUp                  (wingsUp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  // Present one pixel, then park the scan far away so only the right cycle can show a hit.
  task automatic scan(input int x, input int y, input logic exp_req, input logic [7:0] exp_rgb,
                      input string tag);
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    pixelX = 11'd2000;
    pixelY = 11'd2000;
    step();
    check({tag, ".req"}, 32'(drawingRequest), 32'(exp_req));
    check({tag, ".rgb"}, 32'(RGBout), 32'(exp_rgb));
  endtask

  initial begin
    // Frame A default {row[3:0],col[3:0]}; frame B is A xor A5; a few hand-placed overrides.
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        up_mem[r][c]   = {4'(r), 4'(c)};
        down_mem[r][c] = {4'(r), 4'(c)} ^ 8'hA5;
      end
    end
    up_mem[0][2]   = 8'hFF;
    up_mem[5][15]  = 8'hF9;
    up_mem[0][31]  = 8'h00;
    up_mem[1][30]  = 8'h33;
    down_mem[0][0] = 8'hFF;

    reset = 1'b1; startOfFrame = 1'b0; enable = 1'b0; faceLeft = 1'b0;
    pixelX = 11'd2000; pixelY = 11'd2000; topLeftX = 11'd100; topLeftY = 11'd50;
    step(); step(); step();
    check("rst.req", 32'(drawingRequest), 32'd0);
    check("rst.rgb", 32'(RGBout), 32'hFF);
    check("rst.up", 32'(wingsUp), 32'd1);
    reset = 1'b0;

    enable = 1'b1;
    step();
    check("en.up", 32'(wingsUp), 32'd1);

    scan(100, 50, 1'b1, 8'h00, "a00");
    scan(102, 50, 1'b0, 8'hFF, "a02_transp");
    scan(115, 55, 1'b1, 8'hF9, "a5_15");
    scan(99,  50, 1'b0, 8'hFF, "left_edge");
    scan(132, 50, 1'b0, 8'hFF, "right_edge");
    scan(131, 50, 1'b1, 8'h00, "a0_31");
    scan(100, 81, 1'b1, 8'hF0, "a31_0");
    scan(100, 82, 1'b0, 8'hFF, "bottom_edge");
    scan(100, 49, 1'b0, 8'hFF, "top_edge");

    for (int i = 0; i < 7; i++) pulse_sof();
    check("flap7.up", 32'(wingsUp), 32'd1);
    pulse_sof();
    check("flap8.up", 32'(wingsUp), 32'd0);
    scan(100, 50, 1'b0, 8'hFF, "b00_transp");
    scan(103, 53, 1'b1, 8'h96, "b3_3");
    for (int i = 0; i < 7; i++) pulse_sof();
    check("flap15.up", 32'(wingsUp), 32'd0);
    pulse_sof();
    check("flap16.up", 32'(wingsUp), 32'd1);

    topLeftX = 11'h7FB;  // -5
    topLeftY = 11'h7FD;  // -3
    scan(0,  0, 1'b1, 8'h35, "neg_a3_5");
    scan(26, 0, 1'b1, 8'h3F, "neg_a3_31");
    scan(27, 0, 1'b0, 8'hFF, "neg_outside");
    topLeftX = 11'd100;
    topLeftY = 11'd50;

    for (int i = 0; i < 7; i++) pulse_sof();
    enable = 1'b0;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check("dis_sof.up", 32'(wingsUp), 32'd1);
    scan(100, 50, 1'b0, 8'hFF, "disabled");
    enable = 1'b1;
    step();
    check("reen.up", 32'(wingsUp), 32'd1);
    for (int i = 0; i < 7; i++) pulse_sof();
    check("reen7.up", 32'(wingsUp), 32'd1);
    pulse_sof();
    check("reen8.up", 32'(wingsUp), 32'd0);

    // In-flight pixel survives a disable on the following cycle.
    pixelX = 11'd103; pixelY = 11'd53;
    step();
    enable = 1'b0;
    pixelX = 11'd2000; pixelY = 11'd2000;
    step();
    check("inflight.req", 32'(drawingRequest), 32'd1);
    check("inflight.rgb", 32'(RGBout), 32'h96);
    step();
    check("after_dis.req", 32'(drawingRequest), 32'd0);

    // Reset with an opaque pixel in stage 1 must flush it.
    enable = 1'b1;
    step();
    pixelX = 11'd103; pixelY = 11'd53;
    step();
    reset = 1'b1;
    pixelX = 11'd2000; pixelY = 11'd2000;
    step();
    check("midrst.req", 32'(drawingRequest), 32'd0);
    check("midrst.rgb", 32'(RGBout), 32'hFF);
    reset = 1'b0;
    step();
    check("midrst2.req", 32'(drawingRequest), 32'd0);

`ifdef BIRD_MIRROR_EN
    step();
    faceLeft = 1'b1;
    scan(100, 50, 1'b1, 8'h00, "mir_a0_31");
    scan(101, 51, 1'b1, 8'h33, "mir_a1_30");
    faceLeft = 1'b0;
    scan(101, 51, 1'b1, 8'h11, "nomir_a1_1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
